output_allocator: RTL and testbench
===================================

# output_allocator

Per-output-port switch allocator for the dynamic router. It arbitrates among the input units whose head flit routes to this output and drives the crossbar select. Grants are round-robin and wormhole-locked: a granted input keeps the output from HEAD to TAIL flit. Flits cross only when a credit is available in the downstream input queue.

## Interface
- N_IN, 7, number of requesting input units (±X, ±Y, ±Z, local)
- CREDIT_MAX, IN_Q_SIZE, downstream input-queue depth (initial credit count)
- CW, $clog2(CREDIT_MAX+1), credit counter width
- SW, $clog2(N_IN), select width

- clk  in  1  router clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- req  in  N_IN  bit i: input i has a valid flit at queue head destined for this output
- flit_type  in  N_IN*TYPE_W  TYPE field of each input's head flit; slice i = bits [i*TYPE_W +: TYPE_W]
- credit_inc  in  1  downstream freed one queue slot this cycle
- pop  out  N_IN  one-hot; dequeue strobe to the transferring input
- sel  out  SW  crossbar mux select; index of the current/winning input
- valid_out  out  1  a flit crosses the crossbar to this output this cycle
- credit_cnt  out  CW  current downstream credits
- locked  out  1  a packet owns the output
- err  out  1  sticky protocol error

## Operation
- Flit TYPE encodings:
  - BODY = 2'b00
  - HEAD = 2'b01
  - TAIL = 2'b10
  - SINGLE = 2'b11 (head and tail in one flit)
- State machine, two states:
  - IDLE:
    - Candidates are req[i] with type HEAD or SINGLE.
    - If any candidate exists and credit_cnt > 0, the round-robin pick runs starting at rr_ptr (increasing index, wrapping past N_IN-1 to 0).
    - The winner transfers in the same cycle: pop[w]=1, valid_out=1, sel=w.
    - HEAD winner: go to LOCKED with owner=w.
    - SINGLE winner: stay in IDLE and set rr_ptr=(w+1) mod N_IN.
  - LOCKED:
    - Transfer occurs when req[owner] && credit_cnt > 0; then pop[owner]=1, valid_out=1, and sel=owner is held.
    - Other requests are ignored.
    - On a TAIL transfer: go to IDLE and set rr_ptr=(owner+1) mod N_IN.
    - A BODY transfer stays in LOCKED.
    - A HEAD or SINGLE flit from the owner while LOCKED: set err; treat the flit as BODY.
- IDLE with a BODY/TAIL flit as the only request: no grant, err set. The flit stays queued and is not popped.
- Credits (next credit_cnt per cycle):
  - Transfer without credit_inc: credit_cnt-1.
  - credit_inc without transfer: credit_cnt+1.
  - Both in the same cycle: unchanged.
  - credit_inc at CREDIT_MAX: saturates and sets err.
  - A transfer never occurs at credit_cnt=0.
- pop, valid_out and sel are combinational from registered state, req, flit_type and credit_cnt. No other outputs are combinational.
- err clears only on reset.

## Timing
- Zero-cycle grant latency: a request is popped in the cycle it is presented if the conditions hold.
- One flit per cycle maximum. Back-to-back packets are possible: TAIL in cycle t, next HEAD granted in cycle t+1.
- Credit returned in cycle t is usable in cycle t+1.
- Reset values:
  - state=IDLE, owner=0, rr_ptr=0
  - credit_cnt=CREDIT_MAX
  - err=0, locked=0
  - pop=0, valid_out=0, sel=0 while rst is high
- Reset mid-packet: the lock is dropped immediately and credits are restored. Upstream and downstream queues are reset by the same rst.
- While rst is high, req is ignored.

## Structure
- Shared package in para.sv:
  - FLIT_SIZE, TYPE_W=2, IN_Q_SIZE, N_PORTS=7
  - flit type encodings as localparams
  - TYPE field position: FLIT_SIZE-1 downto FLIT_SIZE-TYPE_W
- Sub-module rr_arbiter (#N):
  - Combinational round-robin pick.
  - Inputs: req vector, ptr.
  - Outputs: one-hot gnt, index, any.
  - Implemented by a double-width masked priority scan.
- output_allocator holds the FSM, owner, rr_ptr and credit registers. One instance per router output port.

## Test plan
- Reset, then req=7'b0000001 with SINGLE and credits=4 → pop=0000001, valid_out=1 in the same cycle; credit_cnt=3; rr_ptr=1.
- Inputs 2 and 5 both present HEAD with rr_ptr=0 → input 2 granted and locked. Input 2 sends BODY, BODY, TAIL in 3 cycles while input 5 stalls. Input 5 is granted in the next cycle; sel=5.
- CREDIT_MAX=2, 5-flit packet, credit_inc withheld → 2 flits transfer. valid_out=0 with req high. Pulse credit_inc in cycle t → transfer in cycle t+1.
- Transfer and credit_inc in the same cycle at credit_cnt=1 → credit_cnt stays 1. credit_inc at 2 (CREDIT_MAX) → stays 2 and err=1.
- All 7 inputs issue continuous SINGLE flits → grants in order 0,1,…,6,0. No input is starved.
- Assert rst mid-packet while LOCKED on input 3 → locked=0, credit_cnt=CREDIT_MAX, pop=0 asynchronously. After release, input 6 HEAD is granted.

Source files
------------

// File: rtl/output_allocator_pkg.sv
// Shared router definitions: flit geometry, flit TYPE encodings and helpers.
`default_nettype none

package output_allocator_pkg;

  localparam int FLIT_SIZE = 32;
  localparam int TYPE_W    = 2;
  localparam int IN_Q_SIZE = 4;
  localparam int N_PORTS   = 7;

  // TYPE field occupies the top bits of every flit
  localparam int TYPE_MSB = FLIT_SIZE - 1;
  localparam int TYPE_LSB = FLIT_SIZE - TYPE_W;

  typedef logic [TYPE_W-1:0] flit_type_t;

  localparam flit_type_t FLIT_BODY   = 2'b00;
  localparam flit_type_t FLIT_HEAD   = 2'b01;
  localparam flit_type_t FLIT_TAIL   = 2'b10;
  localparam flit_type_t FLIT_SINGLE = 2'b11;

  function automatic logic opens_packet(input flit_type_t t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/output_allocator_rr_arbiter.sv
// Combinational round-robin pick starting at ptr_i, via a double-width masked scan.
`default_nettype none

module rr_arbiter #(
  parameter int N = 7,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [2*N-1:0] dbl;
  logic           found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    found = 1'b0;
    // Upper copy is never masked, so bits below ptr_i are reached after wrap
    dbl = {req_i, req_i};
    for (int i = 0; i < 2 * N; i++) begin
      if (dbl[i] && (i >= int'(ptr_i)) && !found) begin
        found = 1'b1;
        any_o = 1'b1;
        idx_o = (i >= N) ? W'(i - N) : W'(i);
      end
    end
    if (any_o) gnt_o = N'(1) << idx_o;
  end

endmodule

`default_nettype wire

// File: rtl/output_allocator.sv
// Per-output switch allocator: round-robin, wormhole-locked grants gated by downstream credits.
`default_nettype none

module output_allocator
  import output_allocator_pkg::*;
#(
  parameter int N_IN       = N_PORTS,
  parameter int CREDIT_MAX = IN_Q_SIZE,
  parameter int CW         = $clog2(CREDIT_MAX + 1),
  parameter int SW         = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN-1:0]        req,
  input  logic [N_IN*TYPE_W-1:0] flit_type,
  input  logic                   credit_inc,
  output logic [N_IN-1:0]        pop,
  output logic [SW-1:0]          sel,
  output logic                   valid_out,
  output logic [CW-1:0]          credit_cnt,
  output logic                   locked,
  output logic                   err
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] rr_q, rr_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          err_q, err_d;

  logic [N_IN-1:0] cand;
  logic [N_IN-1:0] arb_gnt;
  logic [SW-1:0]   arb_idx;
  logic            arb_any;
  flit_type_t      win_type, owner_type;
  logic            credit_ok, xfer;
  logic [N_IN-1:0] pop_c;
  logic [SW-1:0]   sel_c;

  function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] p);
    return (p == SW'(N_IN - 1)) ? '0 : SW'(p + 1'b1);
  endfunction

  always_comb begin
    cand = '0;
    for (int i = 0; i < N_IN; i++) begin
      cand[i] = req[i] && opens_packet(flit_type[i*TYPE_W +: TYPE_W]);
    end
  end

  rr_arbiter #(.N(N_IN), .W(SW)) u_arb (
    .req_i (cand),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign win_type   = flit_type[arb_idx*TYPE_W +: TYPE_W];
  assign owner_type = flit_type[owner_q*TYPE_W +: TYPE_W];
  assign credit_ok  = (credit_q != '0);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    err_d    = err_q;
    credit_d = credit_q;
    xfer     = 1'b0;
    pop_c    = '0;
    sel_c    = '0;
    case (state_q)
      S_IDLE: begin
        sel_c = arb_idx;
        if (arb_any && credit_ok) begin
          xfer  = 1'b1;
          pop_c = arb_gnt;
          if (win_type == FLIT_HEAD) begin
            state_d = S_LOCKED;
            owner_d = arb_idx;
          end else begin
            rr_d = next_ptr(arb_idx);
          end
        end else if (!arb_any && (req != '0)) begin
          // Only BODY/TAIL heads present with no open packet: leave them queued
          err_d = 1'b1;
        end
      end
      S_LOCKED: begin
        sel_c = owner_q;
        if (req[owner_q] && credit_ok) begin
          xfer           = 1'b1;
          pop_c[owner_q] = 1'b1;
          if (owner_type == FLIT_TAIL) begin
            state_d = S_IDLE;
            rr_d    = next_ptr(owner_q);
          end else if (opens_packet(owner_type)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (credit_inc && !xfer) begin
      if (credit_q == CW'(CREDIT_MAX)) err_d = 1'b1;
      else credit_d = credit_q + 1'b1;
    end else if (xfer && !credit_inc) begin
      credit_d = credit_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      credit_q <= CW'(CREDIT_MAX);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign pop        = rst ? '0 : pop_c;
  assign valid_out  = rst ? 1'b0 : xfer;
  assign sel        = rst ? '0 : sel_c;
  assign credit_cnt = credit_q;
  assign locked     = (state_q == S_LOCKED);
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_output_allocator.sv
// Directed, table-driven bench for output_allocator (N_IN=7, CREDIT_MAX=4).
`default_nettype none

module tb_output_allocator;

  localparam logic [1:0] B = 2'b00, H = 2'b01, T = 2'b10, S = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  req;
  logic [13:0] flit_type;
  logic        credit_inc;
  logic [6:0]  pop;
  logic [2:0]  sel;
  logic        valid_out;
  logic [2:0]  credit_cnt;
  logic        locked;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  output_allocator dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .flit_type  (flit_type),
    .credit_inc (credit_inc),
    .pop        (pop),
    .sel        (sel),
    .valid_out  (valid_out),
    .credit_cnt (credit_cnt),
    .locked     (locked),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  req;
    logic [13:0] ft;
    logic        inc;
    logic [6:0]  pop;
    logic        v;
    logic        chk_sel;
    logic [2:0]  sel;
    logic [2:0]  cnt;
    logic        lk;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [13:0] ft(input int i, input logic [1:0] t);
    logic [13:0] r;
    r = '0;
    r[i*2 +: 2] = t;
    return r;
  endfunction

  function automatic logic [13:0] ft_all(input logic [1:0] t);
    return {7{t}};
  endfunction

  function automatic vec_t mk(input logic [6:0] rq, input logic [13:0] f, input logic inc,
                              input logic [6:0] p, input logic v, input logic cs,
                              input logic [2:0] s, input logic [2:0] c, input logic lk,
                              input logic er);
    vec_t x;
    x.req = rq; x.ft = f; x.inc = inc; x.pop = p; x.v = v; x.chk_sel = cs;
    x.sel = s; x.cnt = c; x.lk = lk; x.er = er;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] rq, input logic [13:0] f, input logic inc);
    @(negedge clk);
    req = rq; flit_type = f; credit_inc = inc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0; flit_type = '0; credit_inc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 7'h7f; flit_type = ft_all(S); credit_inc = 1'b1;
    #2;
    chk("rst_pop", pop, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_sel", sel, 0);
    chk("rst_cnt", credit_cnt, 4);
    chk("rst_lock", locked, 0);
    chk("rst_err", err, 0);
    do_reset();

    // req, ft, inc | pop, valid, chk_sel, sel, cnt(before edge), locked, err
    tbl.push_back(mk(7'h00, '0,                  0, 7'h00, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk(7'h01, ft(0,S),             0, 7'h01, 1, 1, 0, 4, 0, 0));
    tbl.push_back(mk(7'h00, '0,                  0, 7'h00, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(7'h24, ft(2,H)|ft(5,H),     0, 7'h04, 1, 1, 2, 3, 0, 0));
    tbl.push_back(mk(7'h24, ft(2,B)|ft(5,H),     0, 7'h04, 1, 1, 2, 2, 1, 0));
    tbl.push_back(mk(7'h24, ft(2,B)|ft(5,H),     0, 7'h04, 1, 1, 2, 1, 1, 0));
    tbl.push_back(mk(7'h24, ft(2,T)|ft(5,H),     1, 7'h00, 0, 1, 2, 0, 1, 0));
    tbl.push_back(mk(7'h24, ft(2,T)|ft(5,H),     1, 7'h04, 1, 1, 2, 1, 1, 0));
    tbl.push_back(mk(7'h20, ft(5,H),             0, 7'h20, 1, 1, 5, 1, 0, 0));
    tbl.push_back(mk(7'h20, ft(5,T),             0, 7'h00, 0, 1, 5, 0, 1, 0));
    tbl.push_back(mk(7'h20, ft(5,T),             1, 7'h00, 0, 1, 5, 0, 1, 0));
    tbl.push_back(mk(7'h20, ft(5,T),             0, 7'h20, 1, 1, 5, 1, 1, 0));
    tbl.push_back(mk(7'h00, '0,                  1, 7'h00, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7'h00, '0,                  1, 7'h00, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(7'h00, '0,                  1, 7'h00, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(7'h00, '0,                  1, 7'h00, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(7'h00, '0,                  1, 7'h00, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk(7'h00, '0,                  0, 7'h00, 0, 0, 0, 4, 0, 1));

    foreach (tbl[k]) begin
      drive(tbl[k].req, tbl[k].ft, tbl[k].inc);
      chk($sformatf("v%0d_pop", k), pop, tbl[k].pop);
      chk($sformatf("v%0d_valid", k), valid_out, tbl[k].v);
      if (tbl[k].chk_sel) chk($sformatf("v%0d_sel", k), sel, tbl[k].sel);
      chk($sformatf("v%0d_cnt", k), credit_cnt, tbl[k].cnt);
      chk($sformatf("v%0d_lock", k), locked, tbl[k].lk);
      chk($sformatf("v%0d_err", k), err, tbl[k].er);
    end

    // Reset mid-packet while input 3 owns the output
    do_reset();
    chk("rst2_err", err, 0);
    drive(7'h08, ft(3,H), 0);
    chk("mid_head_pop", pop, 7'h08);
    drive(7'h08, ft(3,B), 0);
    chk("mid_lock", locked, 1);
    chk("mid_cnt", credit_cnt, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_lock", locked, 0);
    chk("mid_rst_cnt", credit_cnt, 4);
    chk("mid_rst_pop", pop, 0);
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_sel", sel, 0);
    @(posedge clk); #1;
    chk("mid_rst_hold_cnt", credit_cnt, 4);
    @(negedge clk);
    rst = 1'b0;
    req = 7'h40; flit_type = ft(6,H); credit_inc = 1'b0;
    #1;
    chk("post_rst_pop", pop, 7'h40);
    chk("post_rst_sel", sel, 6);
    chk("post_rst_valid", valid_out, 1);
    drive(7'h40, ft(6,T), 0);
    chk("post_rst_tail", pop, 7'h40);
    drive(7'h00, '0, 0);
    chk("post_rst_unlock", locked, 0);
    chk("post_rst_cnt", credit_cnt, 2);

    // All inputs stream SINGLE flits: strict rotation starting at 0
    for (int k = 0; k < 8; k++) begin
      drive(7'h7f, ft_all(S), 1);
      chk($sformatf("rr%0d_pop", k), pop, 7'h01 << (k % 7));
      chk($sformatf("rr%0d_sel", k), sel, k % 7);
      chk($sformatf("rr%0d_valid", k), valid_out, 1);
    end
    drive(7'h00, '0, 0);
    chk("rr_err", err, 0);
    chk("rr_cnt", credit_cnt, 2);

    // BODY at queue head with no open packet
    drive(7'h02, ft(1,B), 0);
    chk("orphan_pop", pop, 0);
    chk("orphan_valid", valid_out, 0);
    drive(7'h00, '0, 0);
    chk("orphan_err", err, 1);
    chk("orphan_cnt", credit_cnt, 2);

    // SINGLE from the owner mid-packet: flagged, forwarded as BODY
    do_reset();
    chk("rst3_err", err, 0);
    drive(7'h10, ft(4,H), 0);
    chk("dup_head_pop", pop, 7'h10);
    drive(7'h10, ft(4,S), 0);
    chk("dup_single_pop", pop, 7'h10);
    chk("dup_single_lock", locked, 1);
    drive(7'h10, ft(4,T), 0);
    chk("dup_err", err, 1);
    chk("dup_still_lock", locked, 1);
    chk("dup_tail_pop", pop, 7'h10);
    drive(7'h00, '0, 0);
    chk("dup_unlock", locked, 0);
    chk("dup_cnt", credit_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
